dm_abstract_cmd: RTL and testbench

DM_ABSTRACT_CMD -- requirements
Module: dm_abstract_cmd

---
 rtl/riscv_debug_pkg.sv | 43 ++++
 rtl/dm_abstract_cmd.sv | 147 ++++++++++++++
 tb/tb_dm_abstract_cmd.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_debug_pkg.sv
// Shared debug-module types: abstract command layout, cmderr codes, GPR range, FSM states.
package riscv_debug_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned RegAddrW = 5;
  localparam int unsigned CmdErrW  = 3;

  // Abstract "access register" command word, MSB first.
  typedef struct packed {
    logic [7:0]  cmdtype;
    logic        rsvd23;
    logic [2:0]  aarsize;
    logic        aarpostincrement;
    logic        postexec;
    logic        transfer;
    logic        write;
    logic [15:0] regno;
  } access_reg_cmd_t;

  typedef enum logic [CmdErrW-1:0] {
    CMDERR_NONE          = 3'd0,
    CMDERR_BUSY          = 3'd1,
    CMDERR_NOT_SUPPORTED = 3'd2,
    CMDERR_EXCEPTION     = 3'd3,
    CMDERR_HALT_RESUME   = 3'd4,
    CMDERR_BUS           = 3'd5,
    CMDERR_OTHER         = 3'd7
  } cmderr_e;

  // regno window mapping to x0..x31
  localparam logic [15:0] GPR_REGNO_FIRST = 16'h1000;
  localparam logic [15:0] GPR_REGNO_LAST  = 16'h101F;

  // aarsize encoding for 32-bit accesses
  localparam logic [2:0] AARSIZE_32 = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_WAIT_R = 2'd2
  } dm_cmd_state_e;

endpackage

// File: rtl/dm_abstract_cmd.sv
// Executes abstract access-register commands against the hart GPR port.
module dm_abstract_cmd
  import riscv_debug_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid_i,
  input  logic [XLEN-1:0]     command_i,
  input  logic [XLEN-1:0]     data0_i,
  input  logic [CmdErrW-1:0]  cmderr_clr_i,
  input  logic                hart_halted_i,
  output logic                busy_o,
  output logic [CmdErrW-1:0]  cmderr_o,
  output logic                data0_we_o,
  output logic [XLEN-1:0]     data0_o,
  output logic                reg_req_o,
  output logic                reg_we_o,
  output logic [RegAddrW-1:0] reg_addr_o,
  output logic [XLEN-1:0]     reg_wdata_o,
  input  logic                reg_gnt_i,
  input  logic                reg_rvalid_i,
  input  logic [XLEN-1:0]     reg_rdata_i
);

  localparam int unsigned CntW = 8;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  dm_cmd_state_e         state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  cmderr_e               cmderr_q, cmderr_d;
  logic                  we_q, we_d;
  logic [RegAddrW-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]       wdata_q, wdata_d;
  logic [XLEN-1:0]       data0_q, data0_d;
  logic                  data0_we_q, data0_we_d;

  access_reg_cmd_t cmd;
  logic            regno_is_gpr;
  logic            timed_out;

  assign cmd          = access_reg_cmd_t'(command_i);
  assign regno_is_gpr = (cmd.regno >= GPR_REGNO_FIRST) && (cmd.regno <= GPR_REGNO_LAST);
  assign timed_out    = (cnt_q == CntLast);

  // Next state: command acceptance, GPR handshake, timeout and sticky cmderr.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    data0_d    = data0_q;
    data0_we_d = 1'b0;
    // Clear first so that any error raised below in this cycle overrides it.
    cmderr_d   = cmderr_e'(CmdErrW'(cmderr_q) & ~cmderr_clr_i);

    if (state_q != ST_IDLE && cmd_valid_i && cmderr_q == CMDERR_NONE) begin
      cmderr_d = CMDERR_BUSY;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i && cmderr_q == CMDERR_NONE) begin
          cnt_d = '0;
          if (cmd.cmdtype != 8'd0 || cmd.postexec) begin
            cmderr_d = CMDERR_NOT_SUPPORTED;
          end else if (cmd.transfer && cmd.aarsize != AARSIZE_32) begin
            cmderr_d = CMDERR_NOT_SUPPORTED;
          end else if (!hart_halted_i) begin
            cmderr_d = CMDERR_HALT_RESUME;
          end else if (cmd.transfer && !regno_is_gpr) begin
            cmderr_d = CMDERR_EXCEPTION;
          end else if (cmd.transfer) begin
            state_d = ST_REQ;
            we_d    = cmd.write;
            addr_d  = cmd.regno[RegAddrW-1:0];
            wdata_d = data0_i;
          end
        end
      end
      ST_REQ: begin
        cnt_d = cnt_q + CntW'(1);
        if (reg_gnt_i) begin
          if (we_q) begin
            state_d = ST_IDLE;
          end else if (reg_rvalid_i) begin
            data0_d    = reg_rdata_i;
            data0_we_d = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            state_d = ST_WAIT_R;
          end
        end else if (timed_out) begin
          cmderr_d = CMDERR_OTHER;
          state_d  = ST_IDLE;
        end
      end
      ST_WAIT_R: begin
        cnt_d = cnt_q + CntW'(1);
        if (reg_rvalid_i) begin
          data0_d    = reg_rdata_i;
          data0_we_d = 1'b1;
          state_d    = ST_IDLE;
        end else if (timed_out) begin
          cmderr_d = CMDERR_OTHER;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      cmderr_q   <= CMDERR_NONE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      data0_q    <= '0;
      data0_we_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cmderr_q   <= cmderr_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      data0_q    <= data0_d;
      data0_we_q <= data0_we_d;
    end
  end

  assign busy_o      = (state_q != ST_IDLE);
  assign reg_req_o   = (state_q == ST_REQ);
  assign reg_we_o    = we_q;
  assign reg_addr_o  = addr_q;
  assign reg_wdata_o = wdata_q;
  assign cmderr_o    = CmdErrW'(cmderr_q);
  assign data0_o     = data0_q;
  assign data0_we_o  = data0_we_q;

endmodule

// File: tb/tb_dm_abstract_cmd.sv
// Directed bench for dm_abstract_cmd.
module tb_dm_abstract_cmd;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid_i;
  logic [31:0] command_i;
  logic [31:0] data0_i;
  logic [2:0]  cmderr_clr_i;
  logic        hart_halted_i;
  logic        busy_o;
  logic [2:0]  cmderr_o;
  logic        data0_we_o;
  logic [31:0] data0_o;
  logic        reg_req_o;
  logic        reg_we_o;
  logic [4:0]  reg_addr_o;
  logic [31:0] reg_wdata_o;
  logic        reg_gnt_i;
  logic        reg_rvalid_i;
  logic [31:0] reg_rdata_i;

  int errors = 0;
  int checks = 0;

  // Command words: field layout cmdtype[31:24] aarsize[22:20] transfer[17] write[16] regno[15:0]
  localparam logic [31:0] CMD_RD_X5   = 32'h0022_1005; // aarsize=2, transfer, read, x5
  localparam logic [31:0] CMD_WR_X10  = 32'h0023_100A; // aarsize=2, transfer, write, x10
  localparam logic [31:0] CMD_SZ3     = 32'h0032_1005; // aarsize=3
  localparam logic [31:0] CMD_BADREG  = 32'h0022_1020; // regno 0x1020
  localparam logic [31:0] CMD_TYPE1   = 32'h0122_1005; // cmdtype=1
  localparam logic [31:0] CMD_NOXFER  = 32'h0020_0000; // transfer=0

  dm_abstract_cmd #(.TIMEOUT(255)) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid_i   (cmd_valid_i),
    .command_i     (command_i),
    .data0_i       (data0_i),
    .cmderr_clr_i  (cmderr_clr_i),
    .hart_halted_i (hart_halted_i),
    .busy_o        (busy_o),
    .cmderr_o      (cmderr_o),
    .data0_we_o    (data0_we_o),
    .data0_o       (data0_o),
    .reg_req_o     (reg_req_o),
    .reg_we_o      (reg_we_o),
    .reg_addr_o    (reg_addr_o),
    .reg_wdata_o   (reg_wdata_o),
    .reg_gnt_i     (reg_gnt_i),
    .reg_rvalid_i  (reg_rvalid_i),
    .reg_rdata_i   (reg_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] c);
    cmd_valid_i = 1'b1;
    command_i   = c;
    step();
    cmd_valid_i = 1'b0;
  endtask

  task automatic clear_err();
    cmderr_clr_i = 3'd7;
    step();
    cmderr_clr_i = 3'd0;
  endtask

  initial begin
    rst = 1'b1; cmd_valid_i = 1'b0; command_i = '0; data0_i = '0;
    cmderr_clr_i = '0; hart_halted_i = 1'b0;
    reg_gnt_i = 1'b0; reg_rvalid_i = 1'b0; reg_rdata_i = '0;
    step(); step();
    chk("rst_busy",   32'(busy_o), 32'd0);
    chk("rst_cmderr", 32'(cmderr_o), 32'd0);
    chk("rst_req",    32'(reg_req_o), 32'd0);
    chk("rst_data0",  data0_o, 32'd0);
    chk("rst_we",     32'(data0_we_o), 32'd0);
    rst = 1'b0;
    hart_halted_i = 1'b1;
    step();

    // Read x5: grant at +2, rvalid at +4
    issue(CMD_RD_X5);
    chk("rd_busy_a1", 32'(busy_o), 32'd1);
    chk("rd_req_a1",  32'(reg_req_o), 32'd1);
    chk("rd_addr",    32'(reg_addr_o), 32'd5);
    chk("rd_we",      32'(reg_we_o), 32'd0);
    reg_gnt_i = 1'b1;
    step();
    reg_gnt_i = 1'b0;
    chk("rd_req_wait", 32'(reg_req_o), 32'd0);
    chk("rd_busy_a2",  32'(busy_o), 32'd1);
    step();
    chk("rd_busy_a3",  32'(busy_o), 32'd1);
    chk("rd_nowe_a3",  32'(data0_we_o), 32'd0);
    reg_rvalid_i = 1'b1; reg_rdata_i = 32'hDEADBEEF;
    step();
    reg_rvalid_i = 1'b0; reg_rdata_i = '0;
    chk("rd_data0",   data0_o, 32'hDEADBEEF);
    chk("rd_we_pulse",32'(data0_we_o), 32'd1);
    chk("rd_busy_end",32'(busy_o), 32'd0);
    step();
    chk("rd_we_off",  32'(data0_we_o), 32'd0);
    chk("rd_cmderr",  32'(cmderr_o), 32'd0);

    // Write x10 with data0 captured at acceptance
    data0_i = 32'h12345678;
    issue(CMD_WR_X10);
    data0_i = 32'h0;
    chk("wr_req",   32'(reg_req_o), 32'd1);
    chk("wr_we",    32'(reg_we_o), 32'd1);
    chk("wr_addr",  32'(reg_addr_o), 32'd10);
    chk("wr_wdata", reg_wdata_o, 32'h12345678);
    step();
    chk("wr_wdata_hold", reg_wdata_o, 32'h12345678);
    chk("wr_req_hold",   32'(reg_req_o), 32'd1);
    reg_gnt_i = 1'b1;
    step();
    reg_gnt_i = 1'b0;
    chk("wr_busy_clr", 32'(busy_o), 32'd0);
    chk("wr_req_clr",  32'(reg_req_o), 32'd0);

    // Hart not halted
    hart_halted_i = 1'b0;
    issue(CMD_RD_X5);
    chk("nh_cmderr", 32'(cmderr_o), 32'd4);
    chk("nh_req",    32'(reg_req_o), 32'd0);
    chk("nh_busy",   32'(busy_o), 32'd0);
    hart_halted_i = 1'b1;
    clear_err();
    chk("nh_clr", 32'(cmderr_o), 32'd0);

    // Unsupported size, then ignored command until cleared
    issue(CMD_SZ3);
    chk("sz3_cmderr", 32'(cmderr_o), 32'd2);
    chk("sz3_busy",   32'(busy_o), 32'd0);
    issue(CMD_RD_X5);
    chk("ign_busy",   32'(busy_o), 32'd0);
    chk("ign_cmderr", 32'(cmderr_o), 32'd2);
    clear_err();
    chk("sz3_clr", 32'(cmderr_o), 32'd0);
    issue(CMD_BADREG);
    chk("badreg_cmderr", 32'(cmderr_o), 32'd3);
    chk("badreg_req",    32'(reg_req_o), 32'd0);
    clear_err();

    // Error set and clear in the same cycle: set wins
    cmderr_clr_i = 3'd7;
    issue(CMD_TYPE1);
    cmderr_clr_i = 3'd0;
    chk("setwins_cmderr", 32'(cmderr_o), 32'd2);
    clear_err();

    // transfer=0: no access, no busy, no error
    issue(CMD_NOXFER);
    chk("noxfer_busy",   32'(busy_o), 32'd0);
    chk("noxfer_req",    32'(reg_req_o), 32'd0);
    chk("noxfer_cmderr", 32'(cmderr_o), 32'd0);

    // Command while busy; grant and rvalid in the same cycle
    issue(CMD_RD_X5);
    issue(CMD_WR_X10);
    chk("bz_cmderr", 32'(cmderr_o), 32'd1);
    chk("bz_addr",   32'(reg_addr_o), 32'd5);
    chk("bz_we",     32'(reg_we_o), 32'd0);
    chk("bz_busy",   32'(busy_o), 32'd1);
    reg_gnt_i = 1'b1; reg_rvalid_i = 1'b1; reg_rdata_i = 32'hCAFEF00D;
    step();
    reg_gnt_i = 1'b0; reg_rvalid_i = 1'b0; reg_rdata_i = '0;
    chk("bz_data0", data0_o, 32'hCAFEF00D);
    chk("bz_we_pulse", 32'(data0_we_o), 32'd1);
    chk("bz_busy_end", 32'(busy_o), 32'd0);
    clear_err();

    // Grant withheld: timeout after 255 cycles in REQ
    issue(CMD_RD_X5);
    repeat (200) step();
    chk("to_req_200",  32'(reg_req_o), 32'd1);
    chk("to_busy_200", 32'(busy_o), 32'd1);
    repeat (60) step();
    chk("to_req",    32'(reg_req_o), 32'd0);
    chk("to_busy",   32'(busy_o), 32'd0);
    chk("to_cmderr", 32'(cmderr_o), 32'd7);
    clear_err();

    // Reset while in WAIT_R
    issue(CMD_RD_X5);
    reg_gnt_i = 1'b1;
    step();
    reg_gnt_i = 1'b0;
    chk("rw_busy", 32'(busy_o), 32'd1);
    reg_rvalid_i = 1'b1; reg_rdata_i = 32'h11111111;
    rst = 1'b1;
    #1;
    chk("rw_busy_now",  32'(busy_o), 32'd0);
    chk("rw_data0_now", data0_o, 32'd0);
    chk("rw_we_now",    32'(data0_we_o), 32'd0);
    step();
    chk("rw_we_edge", 32'(data0_we_o), 32'd0);
    chk("rw_data0",   data0_o, 32'd0);
    reg_rvalid_i = 1'b0; reg_rdata_i = '0;
    rst = 1'b0;
    step();
    data0_i = 32'hA5A5A5A5;
    issue(CMD_WR_X10);
    chk("post_req",   32'(reg_req_o), 32'd1);
    chk("post_wdata", reg_wdata_o, 32'hA5A5A5A5);
    reg_gnt_i = 1'b1;
    step();
    reg_gnt_i = 1'b0;
    chk("post_busy",   32'(busy_o), 32'd0);
    chk("post_cmderr", 32'(cmderr_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
